// File: rtl/scan_pkg.sv
// scan_pkg
// Shared types and constants for the channel scan sequencer.
//   SEL_W   : width of the channel select code
//   N_CH    : number of channels, always 2**SEL_W
//   PTR_W   : scan pointer width; one extra bit so ptr == N_CH means "past the end"
//   state_t : sequencer FSM states
package scan_pkg;

  localparam int SEL_W = 3;
  localparam int N_CH  = 1 << SEL_W;
  localparam int PTR_W = SEL_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEEK  = 2'd1,
    DWELL = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/scan_next_ch.sv
// scan_next_ch
// Combinational circular priority finder. Returns the lowest enabled channel
// at or above ptr; if there is none and wrap_en is set, returns the lowest
// enabled channel overall.
// Ports:
//   mask    [N_CH-1:0]  in   channel enables
//   ptr     [PTR_W-1:0] in   first candidate channel (N_CH = past the end)
//   wrap_en             in   allow wrap-around to the bottom of the mask
//   found               out  a channel was selected
//   ch      [SEL_W-1:0] out  selected channel code (0 when not found)
module scan_next_ch
  import scan_pkg::*;
(
  input  logic [N_CH-1:0]  mask,
  input  logic [PTR_W-1:0] ptr,
  input  logic             wrap_en,
  output logic             found,
  output logic [SEL_W-1:0] ch
);

  // Channels enabled and not yet visited in this pass.
  logic [N_CH-1:0] w_fwd_mask;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_fwd
      assign w_fwd_mask[gi] = mask[gi] && (PTR_W'(gi) >= ptr);
    end
  endgenerate

  // The wrap candidate is computed first; a forward hit then overrides it,
  // so forward progress always takes priority over wrapping.
  always_comb begin
    found = 1'b0;
    ch    = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (wrap_en && mask[i]) begin
        found = 1'b1;
        ch    = SEL_W'(i);
      end
    end
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (w_fwd_mask[i]) begin
        found = 1'b1;
        ch    = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// scan_sequencer
// Steps a 3-bit channel select through the channels enabled in a mask,
// holding each for a programmable dwell with one blank cycle between
// channels. Single-pass or continuous operation.
// Ports:
//   clk                 in   rising-edge clock
//   rst_n               in   asynchronous active-low reset
//   start               in   begin scan (sampled in IDLE only)
//   stop                in   abort scan (sampled in every state, wins over start)
//   continuous          in   1 = wrap and repeat (latched with start)
//   mask   [N_CH-1:0]   in   channel enables (latched with start)
//   dwell  [DWELL_W-1:0] in  cycles per channel, 0 treated as 1 (latched with start)
//   sel    [SEL_W-1:0]  out  current channel code for the decoder
//   sel_valid           out  sel is live
//   busy                out  high outside IDLE
//   done                out  one-cycle pulse at end of a single pass
//   err                 out  one-cycle pulse on start with empty mask
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [N_CH-1:0]    mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_valid,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_t             r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [SEL_W-1:0]   r_sel;
  logic               r_sel_valid;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic [DWELL_W-1:0] r_cnt;
  logic [N_CH-1:0]    r_mask;
  logic [DWELL_W-1:0] r_dwell;
  logic               r_cont;

  logic               w_found;
  logic [SEL_W-1:0]   w_ch;
  logic [DWELL_W-1:0] w_cnt_load;

  scan_next_ch u_next_ch (
    .mask    (r_mask),
    .ptr     (r_ptr),
    .wrap_en (r_cont),
    .found   (w_found),
    .ch      (w_ch)
  );

  // max(dwell, 1) - 1: a zero dwell behaves like a one-cycle dwell.
  assign w_cnt_load = (r_dwell == '0) ? '0 : r_dwell - DWELL_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_sel       <= '0;
      r_sel_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
      r_mask      <= '0;
      r_dwell     <= '0;
      r_cont      <= 1'b0;
    end else begin
      // done and err are single-cycle pulses.
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && !stop) begin
            if (mask != '0) begin
              r_mask  <= mask;
              r_dwell <= dwell;
              r_cont  <= continuous;
              r_ptr   <= '0;
              r_busy  <= 1'b1;
              r_state <= SEEK;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        SEEK: begin
          if (stop) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (w_found) begin
            r_sel       <= w_ch;
            r_cnt       <= w_cnt_load;
            // Evaluated at PTR_W bits so channel N_CH-1 yields ptr == N_CH.
            r_ptr       <= PTR_W'(w_ch) + PTR_W'(1);
            r_sel_valid <= 1'b1;
            r_state     <= DWELL;
          end else begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DWELL: begin
          if (stop) begin
            r_sel_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end else if (r_cnt == '0) begin
            r_sel_valid <= 1'b0;
            r_state     <= SEEK;
          end else begin
            r_cnt <= r_cnt - DWELL_W'(1);
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_sel_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign sel       = r_sel;
  assign sel_valid = r_sel_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer
// Directed bench for scan_sequencer. Each task drives one scenario and
// compares the packed observation {sel, sel_valid, busy, done, err} with
// hand-computed values, sampled 1 time unit after each rising edge.
module tb_scan_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        continuous;
  logic [7:0]  mask;
  logic [15:0] dwell;
  logic [2:0]  sel;
  logic        sel_valid;
  logic        busy;
  logic        done;
  logic        err;

  logic [6:0]  obs;
  logic [7:0]  dec;

  int checks = 0;
  int errors = 0;

  scan_sequencer #(.DWELL_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .mask       (mask),
    .dwell      (dwell),
    .sel        (sel),
    .sel_valid  (sel_valid),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  assign obs = {sel, sel_valid, busy, done, err};
  // Model of the downstream 3-to-8 one-hot decoder.
  assign dec = 8'd1 << sel;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    mask = 8'h00; dwell = 16'd0;
    step;
    checks++;
    if (obs !== 7'b000_0000) begin
      errors++;
      $display("FAIL reset_state obs=%b exp=%b", obs, 7'b000_0000);
    end
    rst_n = 1'b1;
    step;
    checks++;
    if (obs !== 7'b000_0000) begin
      errors++;
      $display("FAIL reset_release obs=%b exp=%b", obs, 7'b000_0000);
    end
    $display("test_reset obs=%b", obs);
  endtask

  task automatic test_async_reset_mid_dwell;
    mask = 8'hA5; dwell = 16'd5; continuous = 1'b0; start = 1'b1;
    step;
    start = 1'b0;
    step;
    step;
    checks++;
    if (obs !== {3'd0, 4'b1100}) begin
      errors++;
      $display("FAIL pre_reset_dwell obs=%b exp=%b", obs, {3'd0, 4'b1100});
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 7'b000_0000) begin
      errors++;
      $display("FAIL async_reset obs=%b exp=%b", obs, 7'b000_0000);
    end
    #1 rst_n = 1'b1;
    step;
    checks++;
    if (obs !== 7'b000_0000) begin
      errors++;
      $display("FAIL after_async_reset obs=%b exp=%b", obs, 7'b000_0000);
    end
    $display("test_async_reset_mid_dwell obs=%b", obs);
  endtask

  task automatic test_single_pass;
    logic [2:0] exp_sel [4] = '{3'd0, 3'd2, 3'd5, 3'd7};
    logic [7:0] exp_dec [4] = '{8'h01, 8'h04, 8'h20, 8'h80};
    mask = 8'b1010_0101; dwell = 16'd3; continuous = 1'b0; start = 1'b1;
    step;
    start = 1'b0;
    checks++;
    if (obs[3:0] !== 4'b0100) begin
      errors++;
      $display("FAIL sp_seek obs=%b exp=%b", obs[3:0], 4'b0100);
    end
    for (int c = 0; c < 4; c++) begin
      for (int d = 0; d < 3; d++) begin
        step;
        checks++;
        if (obs !== {exp_sel[c], 4'b1100} || dec !== exp_dec[c]) begin
          errors++;
          $display("FAIL sp_dwell ch%0d cyc%0d obs=%b dec=%h exp=%b dec=%h",
                   c, d, obs, dec, {exp_sel[c], 4'b1100}, exp_dec[c]);
        end
      end
      step;
      checks++;
      if (obs !== {exp_sel[c], 4'b0100}) begin
        errors++;
        $display("FAIL sp_blank ch%0d obs=%b exp=%b", c, obs, {exp_sel[c], 4'b0100});
      end
      $display("test_single_pass ch=%0d dec=%h", exp_sel[c], dec);
    end
    step;
    checks++;
    if (obs !== {3'd7, 4'b0110}) begin
      errors++;
      $display("FAIL sp_done obs=%b exp=%b", obs, {3'd7, 4'b0110});
    end
    step;
    checks++;
    if (obs !== {3'd7, 4'b0000}) begin
      errors++;
      $display("FAIL sp_idle obs=%b exp=%b", obs, {3'd7, 4'b0000});
    end
  endtask

  task automatic test_continuous_stop;
    logic [2:0] s;
    mask = 8'b1000_0001; dwell = 16'd0; continuous = 1'b1; start = 1'b1;
    step;
    start = 1'b0;
    checks++;
    if (obs[3:0] !== 4'b0100) begin
      errors++;
      $display("FAIL cs_seek obs=%b exp=%b", obs[3:0], 4'b0100);
    end
    for (int i = 0; i < 6; i++) begin
      s = (i % 2 == 1) ? 3'd7 : 3'd0;
      step;
      checks++;
      if (obs !== {s, 4'b1100}) begin
        errors++;
        $display("FAIL cs_dwell i%0d obs=%b exp=%b", i, obs, {s, 4'b1100});
      end
      step;
      checks++;
      if (obs !== {s, 4'b0100}) begin
        errors++;
        $display("FAIL cs_blank i%0d obs=%b exp=%b", i, obs, {s, 4'b0100});
      end
      $display("test_continuous_stop i=%0d sel=%0d", i, s);
    end
    step;
    checks++;
    if (obs !== {3'd0, 4'b1100}) begin
      errors++;
      $display("FAIL cs_last_dwell obs=%b exp=%b", obs, {3'd0, 4'b1100});
    end
    // Stop on the final dwell cycle must win over the move to SEEK.
    stop = 1'b1;
    step;
    stop = 1'b0;
    checks++;
    if (obs !== {3'd0, 4'b0000}) begin
      errors++;
      $display("FAIL cs_stop obs=%b exp=%b", obs, {3'd0, 4'b0000});
    end
    step;
    checks++;
    if (obs !== {3'd0, 4'b0000}) begin
      errors++;
      $display("FAIL cs_no_done obs=%b exp=%b", obs, {3'd0, 4'b0000});
    end
  endtask

  task automatic test_err_and_stop_priority;
    mask = 8'h00; dwell = 16'd1; continuous = 1'b0; start = 1'b1;
    step;
    start = 1'b0;
    checks++;
    if (obs[3:0] !== 4'b0001) begin
      errors++;
      $display("FAIL err_pulse obs=%b exp=%b", obs[3:0], 4'b0001);
    end
    step;
    checks++;
    if (obs[3:0] !== 4'b0000) begin
      errors++;
      $display("FAIL err_one_cycle obs=%b exp=%b", obs[3:0], 4'b0000);
    end
    start = 1'b1; stop = 1'b1;
    step;
    checks++;
    if (obs[3:0] !== 4'b0000) begin
      errors++;
      $display("FAIL stop_vs_start_empty obs=%b exp=%b", obs[3:0], 4'b0000);
    end
    mask = 8'hFF;
    step;
    checks++;
    if (obs[3:0] !== 4'b0000) begin
      errors++;
      $display("FAIL stop_vs_start obs=%b exp=%b", obs[3:0], 4'b0000);
    end
    start = 1'b0; stop = 1'b0;
    step;
    checks++;
    if (obs[3:0] !== 4'b0000) begin
      errors++;
      $display("FAIL stop_vs_start_after obs=%b exp=%b", obs[3:0], 4'b0000);
    end
    $display("test_err_and_stop_priority obs=%b", obs);
  endtask

  task automatic test_ignore_while_busy;
    logic [6:0] exp_obs [7] = '{{3'd1, 4'b1100}, {3'd1, 4'b0100}, {3'd2, 4'b1100},
                                {3'd2, 4'b1100}, {3'd2, 4'b0100}, {3'd2, 4'b0110},
                                {3'd2, 4'b0000}};
    mask = 8'b0000_0110; dwell = 16'd2; continuous = 1'b0; start = 1'b1;
    step;
    start = 1'b0;
    step;
    checks++;
    if (obs !== {3'd1, 4'b1100}) begin
      errors++;
      $display("FAIL ib_first obs=%b exp=%b", obs, {3'd1, 4'b1100});
    end
    // New settings and a fresh start mid-scan must have no effect.
    mask = 8'b1000_0001; dwell = 16'd7; continuous = 1'b1; start = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step;
      start = 1'b0;
      checks++;
      if (obs !== exp_obs[i]) begin
        errors++;
        $display("FAIL ib_seq i%0d obs=%b exp=%b", i, obs, exp_obs[i]);
      end
      $display("test_ignore_while_busy i=%0d obs=%b", i, obs);
    end
  endtask

  task automatic test_single_channel_repeat;
    mask = 8'b0001_0000; dwell = 16'd2; continuous = 1'b1; start = 1'b1;
    step;
    start = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int d = 0; d < 2; d++) begin
        step;
        checks++;
        if (obs !== {3'd4, 4'b1100}) begin
          errors++;
          $display("FAIL scr_dwell r%0d d%0d obs=%b exp=%b", r, d, obs, {3'd4, 4'b1100});
        end
      end
      step;
      checks++;
      if (obs !== {3'd4, 4'b0100}) begin
        errors++;
        $display("FAIL scr_blank r%0d obs=%b exp=%b", r, obs, {3'd4, 4'b0100});
      end
      $display("test_single_channel_repeat rep=%0d sel=%0d", r, sel);
    end
    step;
    stop = 1'b1;
    step;
    stop = 1'b0;
    checks++;
    if (obs !== {3'd4, 4'b0000}) begin
      errors++;
      $display("FAIL scr_stop obs=%b exp=%b", obs, {3'd4, 4'b0000});
    end
  endtask

  initial begin
    test_reset;
    test_async_reset_mid_dwell;
    test_single_pass;
    test_continuous_stop;
    test_err_and_stop_priority;
    test_ignore_while_busy;
    test_single_channel_repeat;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
